// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder
//  Description : Parametrised pipelined adder. A WIDTH-bit add is split into
//                STAGES ripple chunks of CHUNK = WIDTH/STAGES bits. One chunk
//                is resolved per clock, and the carry is registered between
//                chunks. Valid/ready handshakes are used on both sides, and
//                the adder sustains one beat per cycle when not stalled.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      operand/sum width; must be a multiple of STAGES
//    STAGES     number of pipeline stages (= chunks), >= 1
//  Ports
//    clk        rising-edge clock
//    rst        asynchronous active-high reset
//    in_valid   operand beat present
//    in_ready   beat accepted this cycle (low while output is stalled)
//    a, b       operands
//    cin        carry-in (borrow-in when subtracting)
//    sub        1 = subtract (only when ADDER_SUB_EN is defined)
//    out_valid  result beat present
//    out_ready  downstream accepts result
//    sum        result
//    cout       carry-out of MSB (inverted borrow when subtracting)
//    ovf        signed overflow
//  Configuration macro
//    ADDER_SUB_EN  adds the `sub` port and the subtract mode
// ============================================================================
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    // Register k holds the beat after chunk k has been resolved.
    // The last register is the output register.
    logic             valid_q [STAGES];
    logic             valid_d [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [WIDTH-1:0] s_q     [STAGES];
    logic [WIDTH-1:0] s_d     [STAGES];
    logic             c_q     [STAGES];
    logic             c_d     [STAGES];
    logic             ovf_q;
    logic             ovf_d;

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             op_v;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_s;
    logic             op_c;
    logic [CHUNK:0]   chunk_sum;

    always_comb begin
        // A full output register that cannot drain freezes the whole pipe.
        stall = valid_q[STAGES-1] & ~out_ready;

        // Subtraction is a + ~b + ~cin. Inverting B once at entry lets the
        // inverted operand travel with the beat, so `sub` is sampled once.
`ifdef ADDER_SUB_EN
        b_eff   = sub ? ~b : b;
        cin_eff = sub ? ~cin : cin;
`else
        b_eff   = b;
        cin_eff = cin;
`endif

        valid_d   = valid_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        c_d       = c_q;
        ovf_d     = ovf_q;
        op_v      = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_s      = '0;
        op_c      = 1'b0;
        chunk_sum = '0;

        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                op_v = in_valid;
                op_a = a;
                op_b = b_eff;
                op_s = '0;
                op_c = cin_eff;
            end else begin
                op_v = valid_q[(k == 0) ? 0 : k - 1];
                op_a = a_q[(k == 0) ? 0 : k - 1];
                op_b = b_q[(k == 0) ? 0 : k - 1];
                op_s = s_q[(k == 0) ? 0 : k - 1];
                op_c = c_q[(k == 0) ? 0 : k - 1];
            end

            chunk_sum = {1'b0, op_a[k*CHUNK +: CHUNK]}
                      + {1'b0, op_b[k*CHUNK +: CHUNK]}
                      + {{CHUNK{1'b0}}, op_c};
            op_s[k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];

            if (!stall) begin
                valid_d[k] = op_v;
                a_d[k]     = op_a;
                b_d[k]     = op_b;
                s_d[k]     = op_s;
                c_d[k]     = chunk_sum[CHUNK];
                // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
                if (k == STAGES - 1) begin
                    ovf_d = op_a[WIDTH-1] ^ op_b[WIDTH-1]
                          ^ chunk_sum[CHUNK-1] ^ chunk_sum[CHUNK];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                s_q[k]     <= '0;
                c_q[k]     <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = ~stall;
    assign out_valid = valid_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule
`default_nettype wire
